// File: rtl/mul_add_reconstruct.sv
// Sequential radix-2 shift-and-add multiply-accumulate: P = Q*M + R.
// Rebuilds a dividend from divider outputs; one bit of Q is consumed per clock.
module mul_add_reconstruct #(
  parameter int WIDTH = 2048
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   Q,
  input  logic [WIDTH-1:0]   M,
  input  logic [WIDTH-1:0]   R,
  output logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_ADD  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH:0]     hi_q, hi_d;
  logic [WIDTH-1:0]   mreg_q, mreg_d;
  logic [WIDTH-1:0]   rreg_q, rreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH:0]     sum_s;

  // Partial-product add keeps the carry in bit WIDTH; the shift below folds it back in.
  assign sum_s = hi_q + (lo_q[0] ? {1'b0, mreg_q} : {(WIDTH+1){1'b0}});

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    mreg_d  = mreg_q;
    rreg_d  = rreg_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          lo_d    = Q;
          mreg_d  = M;
          rreg_d  = R;
          hi_d    = {(WIDTH+1){1'b0}};
          cnt_d   = CNT_W'(WIDTH);
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_RUN: begin
        hi_d  = {1'b0, sum_s[WIDTH:1]};
        lo_d  = {sum_s[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_d = S_ADD;
        end else begin
          state_d = S_RUN;
        end
      end
      S_ADD: begin
        // Cannot overflow: (2^W-1)^2 + (2^W-1) < 2^(2W).
        p_d     = {hi_q[WIDTH-1:0], lo_q} + {{WIDTH{1'b0}}, rreg_q};
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lo_q    <= {WIDTH{1'b0}};
      hi_q    <= {(WIDTH+1){1'b0}};
      mreg_q  <= {WIDTH{1'b0}};
      rreg_q  <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      p_q     <= {(2*WIDTH){1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      mreg_q  <= mreg_d;
      rreg_q  <= rreg_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign P    = p_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
